// File: rtl/spec_config_pkg.sv
// Shared constants and commit state encoding for the spec_config_loader block.
// Optional read-back is enabled by defining SPEC_CONFIG_READBACK_EN.
package spec_config_pkg;

   localparam int CONFIG_WIDTH   = 550;
   localparam int WORD_WIDTH     = 32;
   localparam int ADDR_WIDTH     = 32;
   localparam int NUM_WORDS      = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int LAST_WORD_BITS = CONFIG_WIDTH - (NUM_WORDS - 1) * WORD_WIDTH;
   localparam int COMMIT_ADDR    = NUM_WORDS;
   localparam int STATUS_ADDR    = NUM_WORDS + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_APPLY   = 2'd2
   } commit_state_e;

endpackage

// File: rtl/spec_config_loader_if.sv
// Config bus bundle between the CGRA configuration master and spec_config_loader.
interface spec_config_loader_if #(
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] config_config_addr;
   logic [WORD_WIDTH-1:0] config_config_data;
   logic                  config_write;
   logic                  config_read;
   logic [WORD_WIDTH-1:0] config_rd_data;
   logic                  config_rd_valid;
   logic                  config_err;

   modport master (
      output config_config_addr, config_config_data, config_write, config_read,
      input  config_rd_data, config_rd_valid, config_err
   );

   modport slave (
      input  config_config_addr, config_config_data, config_write, config_read,
      output config_rd_data, config_rd_valid, config_err
   );
endinterface

// File: rtl/spec_config_readback_mux.sv
// Read-back path: selects a shadow word or the status word and registers it.
// Only instantiated when SPEC_CONFIG_READBACK_EN is defined.
module spec_config_readback_mux #(
   parameter int WORD_WIDTH = 32,
   parameter int N_WORDS    = 18,
   parameter int IDX_W      = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rd_en,
   input  logic                          rd_status,
   input  logic [IDX_W-1:0]              rd_idx,
   input  logic [N_WORDS*WORD_WIDTH-1:0] words,
   input  logic                          pending,
   input  logic                          complete,
   output logic [WORD_WIDTH-1:0]         rd_data,
   output logic                          rd_valid
);

   logic [WORD_WIDTH-1:0] words_a [N_WORDS];
   logic [WORD_WIDTH-1:0] word_s;
   logic [WORD_WIDTH-1:0] rd_data_r;
   logic                  rd_valid_r;

   // Split the padded shadow into addressable words.
   always_comb begin
      for (int i = 0; i < N_WORDS; i++) begin
         words_a[i] = words[i*WORD_WIDTH +: WORD_WIDTH];
      end
   end

   // Pick status or the addressed word.
   always_comb begin
      word_s = '0;
      if (rd_status) begin
         word_s = {{(WORD_WIDTH-2){1'b0}}, complete, pending};
      end else begin
         word_s = words_a[rd_idx];
      end
   end

   // Read register: data holds between reads, valid pulses once per read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_r  <= '0;
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= rd_en;
         if (rd_en) begin
            rd_data_r <= word_s;
         end else begin
            rd_data_r <= rd_data_r;
         end
      end
   end

   assign rd_data  = rd_data_r;
   assign rd_valid = rd_valid_r;

endmodule

// File: rtl/spec_config_loader.sv
// Shadow-register config loader: bus writes fill a shadow, a stalled commit copies it to the datapath.
// Define SPEC_CONFIG_READBACK_EN to enable shadow/status reads.
module spec_config_loader #(
   parameter int CONFIG_WIDTH = spec_config_pkg::CONFIG_WIDTH,
   parameter int WORD_WIDTH   = spec_config_pkg::WORD_WIDTH,
   parameter int ADDR_WIDTH   = spec_config_pkg::ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall,
   spec_config_loader_if.slave     bus,
   output logic [CONFIG_WIDTH-1:0] config_memory_size_550,
   output logic                    config_complete,
   output logic                    commit_done
);
   import spec_config_pkg::*;

   localparam int N_WORDS   = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int LAST_BITS = CONFIG_WIDTH - (N_WORDS - 1) * WORD_WIDTH;
   localparam int FLAT_W    = N_WORDS * WORD_WIDTH;
   localparam int IDX_W     = $clog2(N_WORDS);
   localparam logic [ADDR_WIDTH-1:0] COMMIT_A = ADDR_WIDTH'(N_WORDS);
   localparam logic [ADDR_WIDTH-1:0] STATUS_A = ADDR_WIDTH'(N_WORDS + 1);

   logic [CONFIG_WIDTH-1:0] shadow_r;
   logic [CONFIG_WIDTH-1:0] active_r;
   logic [N_WORDS-1:0]      mask_r;
   logic [N_WORDS-1:0]      mask_next_s;
   logic                    complete_r;
   logic                    commit_done_r;
   logic                    err_r;
   commit_state_e           state_r;
   commit_state_e           state_next_s;

   logic                    wr_s;
   logic                    rd_s;
   logic                    both_s;
   logic                    word_addr_s;
   logic                    word_wr_s;
   logic                    commit_wr_s;
   logic                    rd_ok_s;
   logic                    illegal_s;
   logic                    apply_s;
   logic [IDX_W-1:0]        idx_s;

   // Address decode and legality of the current bus access.
   always_comb begin
`ifdef SPEC_CONFIG_READBACK_EN
      both_s = bus.config_write & bus.config_read;
      wr_s   = bus.config_write & ~bus.config_read;
      rd_s   = bus.config_read & ~bus.config_write;
`else
      both_s = 1'b0;
      wr_s   = bus.config_write;
      rd_s   = 1'b0;
`endif
      idx_s       = bus.config_config_addr[IDX_W-1:0];
      word_addr_s = (bus.config_config_addr < ADDR_WIDTH'(N_WORDS));
      word_wr_s   = wr_s & word_addr_s;
      commit_wr_s = wr_s & (bus.config_config_addr == COMMIT_A);
      rd_ok_s     = rd_s & (word_addr_s | (bus.config_config_addr == STATUS_A));
      illegal_s   = both_s | (wr_s & ~word_addr_s & ~commit_wr_s) | (rd_s & ~rd_ok_s);
   end

   // Commit sequencing: a pending commit waits for stall, then copies on that edge.
   always_comb begin
      state_next_s = state_r;
      apply_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (commit_wr_s) begin
               state_next_s = ST_PENDING;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_PENDING: begin
            if (stall) begin
               state_next_s = ST_APPLY;
               apply_s      = 1'b1;
            end else begin
               state_next_s = ST_PENDING;
            end
         end
         ST_APPLY: begin
            if (commit_wr_s) begin
               state_next_s = ST_PENDING;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Written-word mask; a write landing on the apply edge counts toward the next commit.
   always_comb begin
      if (apply_s) begin
         mask_next_s = '0;
      end else begin
         mask_next_s = mask_r;
      end
      if (word_wr_s) begin
         mask_next_s[idx_s] = 1'b1;
      end else begin
         mask_next_s = mask_next_s;
      end
   end

   // Shadow word storage; the last word keeps only its in-range bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_r <= '0;
      end else if (word_wr_s) begin
         for (int i = 0; i < N_WORDS - 1; i++) begin
            if (idx_s == IDX_W'(i)) begin
               shadow_r[i*WORD_WIDTH +: WORD_WIDTH] <= bus.config_config_data;
            end
         end
         if (idx_s == IDX_W'(N_WORDS - 1)) begin
            shadow_r[CONFIG_WIDTH-1 -: LAST_BITS] <= bus.config_config_data[LAST_BITS-1:0];
         end
      end
   end

   // Commit state, active configuration and status/error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         active_r      <= '0;
         mask_r        <= '0;
         complete_r    <= 1'b0;
         commit_done_r <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         mask_r        <= mask_next_s;
         complete_r    <= &mask_next_s;
         commit_done_r <= apply_s;
         err_r         <= illegal_s;
         if (apply_s) begin
            active_r <= shadow_r;
         end
      end
   end

`ifdef SPEC_CONFIG_READBACK_EN
   logic [FLAT_W-1:0] words_s;
   assign words_s = FLAT_W'(shadow_r);

   spec_config_readback_mux #(
      .WORD_WIDTH (WORD_WIDTH),
      .N_WORDS    (N_WORDS),
      .IDX_W      (IDX_W)
   ) u_readback (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_ok_s),
      .rd_status (~word_addr_s),
      .rd_idx    (idx_s),
      .words     (words_s),
      .pending   (state_r == ST_PENDING),
      .complete  (complete_r),
      .rd_data   (bus.config_rd_data),
      .rd_valid  (bus.config_rd_valid)
   );
`else
   assign bus.config_rd_data  = '0;
   assign bus.config_rd_valid = 1'b0;
`endif

   assign bus.config_err             = err_r;
   assign config_memory_size_550     = active_r;
   assign config_complete            = complete_r;
   assign commit_done                = commit_done_r;

endmodule

// File: tb/tb_spec_config_loader.sv
// Self-checking bench for spec_config_loader: directed table, test-plan sequences and random traffic.
module tb_spec_config_loader;

`ifdef SPEC_CONFIG_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         stall = 1'b0;
   logic [549:0] cfg_vec;
   logic         complete;
   logic         done;

   spec_config_loader_if #(.WORD_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   spec_config_loader #(.CONFIG_WIDTH(550), .WORD_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .stall                  (stall),
      .bus                    (bus),
      .config_memory_size_550 (cfg_vec),
      .config_complete        (complete),
      .commit_done            (done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state: what the spec says the block holds.
   logic [31:0]  m_shadow [18];
   bit   [17:0]  m_written;
   bit           m_pending;
   logic [549:0] m_active;
   logic [31:0]  e_rdata;
   bit           e_valid, e_err, e_done, e_complete;

   typedef struct {
      bit          w;
      bit          r;
      logic [31:0] a;
      logic [31:0] d;
      bit          e_err;
      bit          e_valid;
      logic [31:0] e_data;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [549:0] act, input logic [549:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [549:0] pack_model();
      logic [549:0] v;
      v = '0;
      for (int i = 0; i < 17; i++) v[i*32 +: 32] = m_shadow[i];
      v[549:544] = m_shadow[17][5:0];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 18; i++) m_shadow[i] = 32'h0;
      m_written  = '0;
      m_pending  = 1'b0;
      m_active   = '0;
      e_rdata    = 32'h0;
      e_valid    = 1'b0;
      e_err      = 1'b0;
      e_done     = 1'b0;
      e_complete = 1'b0;
   endtask

   // One clock edge of the specified behaviour.
   task automatic model_step(input bit w, input bit r, input bit st, input logic [31:0] a, input logic [31:0] d);
      bit wr, rd, both, word_a, legal_rd, fire, all_pre;
      all_pre = &m_written;
      if (RB) begin
         both = w && r; wr = w && !r; rd = r && !w;
      end else begin
         both = 1'b0; wr = w; rd = 1'b0;
      end
      word_a   = (a < 32'd18);
      legal_rd = rd && (word_a || a == 32'd19);
      e_err    = both || (wr && !word_a && a != 32'd18) || (rd && !legal_rd);
      e_valid  = legal_rd;
      if (legal_rd) e_rdata = (a == 32'd19) ? {30'b0, all_pre, m_pending} : m_shadow[a[4:0]];
      fire   = m_pending && st;
      e_done = fire;
      if (fire) begin
         m_active  = pack_model();
         m_written = '0;
         m_pending = 1'b0;
      end else if (wr && a == 32'd18) begin
         m_pending = 1'b1;
      end
      if (wr && word_a) begin
         m_shadow[a[4:0]]  = (a == 32'd17) ? (d & 32'h3F) : d;
         m_written[a[4:0]] = 1'b1;
      end
      e_complete = &m_written;
   endtask

   task automatic cyc(input bit w, input bit r, input bit st, input logic [31:0] a, input logic [31:0] d);
      bus.config_write       = w;
      bus.config_read        = r;
      bus.config_config_addr = a;
      bus.config_config_data = d;
      stall                  = st;
      @(posedge clk);
      model_step(w, r, st, a, d);
      #1;
      chk("rd_data",  bus.config_rd_data,  e_rdata);
      chk("rd_valid", bus.config_rd_valid, e_valid);
      chk("err",      bus.config_err,      e_err);
      chk("done",     done,                e_done);
      chk("complete", complete,            e_complete);
      chk("active",   cfg_vec,             m_active);
   endtask

   task automatic do_reset();
      bus.config_write = 1'b0;
      bus.config_read  = 1'b0;
      stall            = 1'b0;
      rst_n            = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_data"},  bus.config_rd_data,  32'h0);
      chk({tag, "_rd_valid"}, bus.config_rd_valid, 1'b0);
      chk({tag, "_err"},      bus.config_err,      1'b0);
      chk({tag, "_done"},     done,                1'b0);
      chk({tag, "_complete"}, complete,            1'b0);
      chk({tag, "_active"},   cfg_vec,             550'h0);
   endtask

   initial begin
      logic [31:0] m;
      m = RB ? 32'hFFFF_FFFF : 32'h0;
      tbl[0]  = '{1'b1, 1'b0, 32'd3,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 1'b1, 32'd3,  32'h0,         1'b0, RB,   32'hDEAD_BEEF & m};
      tbl[2]  = '{1'b1, 1'b0, 32'd17, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hDEAD_BEEF & m};
      tbl[3]  = '{1'b0, 1'b1, 32'd17, 32'h0,         1'b0, RB,   32'h3F & m};
      tbl[4]  = '{1'b1, 1'b0, 32'd25, 32'h1234,      1'b1, 1'b0, 32'h3F & m};
      tbl[5]  = '{1'b1, 1'b0, 32'd19, 32'h3,         1'b1, 1'b0, 32'h3F & m};
      tbl[6]  = '{1'b0, 1'b1, 32'd18, 32'h0,         RB,   1'b0, 32'h3F & m};
      tbl[7]  = '{1'b1, 1'b1, 32'd5,  32'h1234_5678, RB,   1'b0, 32'h3F & m};
      tbl[8]  = '{1'b0, 1'b1, 32'd25, 32'h0,         RB,   1'b0, 32'h3F & m};
      tbl[9]  = '{1'b0, 1'b1, 32'd19, 32'h0,         1'b0, RB,   32'h0};
      tbl[10] = '{1'b0, 1'b1, 32'd3,  32'h0,         1'b0, RB,   32'hDEAD_BEEF & m};

      bus.config_write       = 1'b0;
      bus.config_read        = 1'b0;
      bus.config_config_addr = 32'h0;
      bus.config_config_data = 32'h0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Directed access table: readback, last-word truncation, illegal accesses.
      for (int k = 0; k < 11; k++) begin
         cyc(tbl[k].w, tbl[k].r, 1'b0, tbl[k].a, tbl[k].d);
         chk("tbl_err",     bus.config_err,      tbl[k].e_err);
         chk("tbl_valid",   bus.config_rd_valid, tbl[k].e_valid);
         chk("tbl_rd_data", bus.config_rd_data,  tbl[k].e_data);
      end

      // Full load and commit with stall already high.
      do_reset();
      for (int i = 0; i < 18; i++) cyc(1'b1, 1'b0, 1'b0, 32'(i), 32'hA5A5_0000 + 32'(i));
      chk("p1_complete", complete, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 32'd18, 32'hFFFF_FFFF);
      chk("p1_done_early", done, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'd0, 32'h0);
      chk("p1_done", done, 1'b1);
      chk("p1_word0", cfg_vec[31:0], 32'hA5A5_0000);
      chk("p1_word17", cfg_vec[549:544], 6'h11);
      chk("p1_complete_clr", complete, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'd0, 32'h0);
      chk("p1_done_pulse", done, 1'b0);

      // Commit deferred while the fabric runs.
      do_reset();
      for (int i = 0; i < 18; i++) cyc(1'b1, 1'b0, 1'b0, 32'(i), $urandom);
      cyc(1'b1, 1'b0, 1'b0, 32'd18, 32'h0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
         chk("p2_active_held", cfg_vec, 550'h0);
      end
      cyc(1'b0, 1'b1, 1'b0, 32'd19, 32'h0);
      chk("p2_status_pend", bus.config_rd_data, 32'h3 & m);
      cyc(1'b0, 1'b0, 1'b1, 32'd0, 32'h0);
      chk("p2_done", done, 1'b1);
      chk("p2_active", cfg_vec, pack_model());
      cyc(1'b0, 1'b1, 1'b1, 32'd19, 32'h0);
      chk("p2_status_idle", bus.config_rd_data, 32'h0);
      chk("p2_status_valid", bus.config_rd_valid, RB);

      // Completeness tracking.
      do_reset();
      for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 1'b0, 32'(i), 32'(i * 7));
      chk("p5_incomplete", complete, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 32'd17, 32'h2A);
      chk("p5_complete", complete, 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 32'd18, 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 32'd0, 32'h0);
      chk("p5_cleared", complete, 1'b0);

      // Reset while a commit is pending.
      cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'h5555_AAAA);
      cyc(1'b1, 1'b0, 1'b0, 32'd18, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      model_reset();
      bus.config_write = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 32'd0, 32'h0);
         chk("p6_no_commit", done, 1'b0);
         chk("p6_active_zero", cfg_vec, 550'h0);
      end

      // Random traffic against the reference model.
      do_reset();
      for (int n = 0; n < 800; n++) begin
         int          op;
         bit          w, r, st;
         logic [31:0] a;
         op = $urandom_range(0, 9);
         w  = (op <= 4) || (op == 8);
         r  = (op >= 5) && (op <= 8);
         st = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) a = 32'h0001_0000 | 32'($urandom_range(0, 19));
         else a = 32'($urandom_range(0, 21));
         if (w && !r && $urandom_range(0, 7) == 0) a = 32'd18;
         cyc(w, r, st, a, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spec_config_loader.md
# spec_config_loader

Configuration responder for the lake spec-generated datapath. Accepts word-wide addr/data configuration writes and reads from the CGRA config bus, assembles them in a shadow register, and on an explicit commit transfers the shadow into the flat 550-bit configuration vector consumed by `lakespec` (`config_memory_size_550`). Commits are deferred until the fabric is stalled, so the datapath never sees a half-written configuration.

## Interface
Parameters:
- `CONFIG_WIDTH`, 550: width of the flat configuration vector.
- `WORD_WIDTH`, 32: config bus data width.
- `ADDR_WIDTH`, 32: config bus address width.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  high = fabric halted; commits are applied only while high.
- `config_config_addr`  in  ADDR_WIDTH  word address.
- `config_config_data`  in  WORD_WIDTH  write data.
- `config_write`  in  1  write strobe, one word per cycle.
- `config_read`  in  1  read strobe.
- `config_rd_data`  out  WORD_WIDTH  registered read data.
- `config_rd_valid`  out  1  one-cycle pulse qualifying `config_rd_data`.
- `config_err`  out  1  one-cycle pulse on illegal access.
- `config_memory_size_550`  out  CONFIG_WIDTH  active configuration to datapath.
- `config_complete`  out  1  high when every shadow word has been written since the last commit.
- `commit_done`  out  1  one-cycle pulse when active config is updated.

## Operation
- NUM_WORDS = ceil(CONFIG_WIDTH/WORD_WIDTH) = 18. Word i maps to bits [i*32 +: 32]; word 17 holds only bits 549:544 (6 valid bits), upper 26 bits discarded on write, read as 0.
- Address map: 0..17 shadow words; 18 = COMMIT (write only, data ignored); 19 = STATUS (read only: bit0 commit pending, bit1 `config_complete`, others 0). Any other address, a write to 19, or a read of 18 -> `config_err`, no state change.
- Write to word i: shadow word updated at the edge; written-mask bit i set. `config_complete` = AND of mask.
- Write to COMMIT: sets pending. State machine IDLE -> PENDING -> (stall=1) APPLY -> IDLE. APPLY copies shadow to active, clears mask, pulses `commit_done`. If stall already 1 at the COMMIT write, APPLY occurs on the following edge.
- Writes to shadow while PENDING are accepted and included in the eventual copy. A second COMMIT while PENDING is absorbed (no error).
- `config_write` and `config_read` both high in one cycle: illegal, neither executes, `config_err` pulses.
- Shadow is never visible to the datapath except through APPLY.

## Timing
- Reset values: all outputs 0; shadow, active, mask, pending, state IDLE.
- Read latency 1: strobe at edge N -> `config_rd_data`/`config_rd_valid` valid after edge N+1; `config_rd_data` holds until next read.
- Read of a shadow word written in the same prior cycle returns new data (write at N, read at N+1 -> new value).
- `config_err` asserted after edge N+1 for illegal access at edge N, one cycle.
- Commit: COMMIT write at edge N with stall=1 -> active updated and `commit_done` high after edge N+1. With stall=0, APPLY at first edge after stall rises +1.
- Reset mid-PENDING: pending discarded, active returns to 0.
- No back-pressure: bus accepts one access per cycle unconditionally.

## Configuration
- `SPEC_CONFIG_READBACK_EN` defined: shadow/STATUS reads supported as above.
- Not defined: `config_read` ignored (no error, no valid), `config_rd_data` and `config_rd_valid` tied 0; simultaneous read+write treated as plain write. Write, commit and error on bad write address unchanged.

## Structure
- Package `spec_config_pkg`: CONFIG_WIDTH, WORD_WIDTH, NUM_WORDS, LAST_WORD_BITS, COMMIT_ADDR, STATUS_ADDR, commit state enum.
- Sub-module `spec_config_readback_mux` (word/status select + read register), instantiated only under `SPEC_CONFIG_READBACK_EN`.

## Test plan
- Reset, write words 0..17 with 0xA5A5_0000+i, commit with stall=1 -> `commit_done` one cycle later; `config_memory_size_550[31:0]`=0xA5A50000, bits 549:544 = 0x11 & 0x3F = 0x11.
- Write all words, commit with stall=0 for 5 cycles -> active stays 0, STATUS reads 0x3; raise stall -> active updated next edge, STATUS reads 0x0.
- Write word 3 = 0xDEADBEEF, read addr 3 next cycle -> `config_rd_valid`, data 0xDEADBEEF; write word 17 = 0xFFFFFFFF, read -> 0x0000003F.
- Access addr 25, write addr 19, read addr 18, read+write same cycle -> four `config_err` pulses, no state change.
- Write 17 words only -> `config_complete`=0; write last -> 1; commit -> 0.
- Assert rst_n low during PENDING -> all outputs 0, later stall=1 produces no commit.
